// File: rtl/fetch_npc_if.sv
// Next-PC generator bus: hazard/branch inputs in, registered
// next-PC and fetch flags out.
interface fetch_npc_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pc;
  logic                stall;
  logic                halt;
  logic                br_taken;
  logic [PC_WIDTH-1:0] br_target;
  logic                jmp;
  logic [PC_WIDTH-1:0] jmp_target;
  logic [PC_WIDTH-1:0] npc;
  logic                pc_en;
  logic                if_valid;
  logic                busy_redir;

  modport master (
    input  pc, stall, halt,
    input  br_taken, br_target,
    input  jmp, jmp_target,
    output npc, pc_en,
    output if_valid, busy_redir
  );

  modport slave (
    output pc, stall, halt,
    output br_taken, br_target,
    output jmp, jmp_target,
    input  npc, pc_en,
    input  if_valid, busy_redir
  );
endinterface

// File: rtl/fetch_npc_gen.sv
// Next-PC generator: sequential/branch/jump select, stall-time
// redirect capture, post-redirect flush bubbles and halt.
module fetch_npc_gen #(
  parameter int PC_WIDTH     = 32,
  parameter int RESET_PC     = 0,
  parameter int PC_INC       = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_npc_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RUN, STALL, FLUSH, HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] W_RST =
    PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] W_INC =
    PC_WIDTH'(PC_INC);
  localparam logic [2:0] CNT_INIT =
    3'(FLUSH_CYCLES - 1);
  localparam state_t POST_REDIR =
    (FLUSH_CYCLES <= 1) ? RUN : FLUSH;

  state_t              r_state, w_state;
  logic [PC_WIDTH-1:0] r_npc, w_npc;
  logic                r_pc_en, w_pc_en;
  logic                r_iv, w_iv;
  logic                r_busy, w_busy;
  logic [PC_WIDTH-1:0] r_pend, w_pend;
  logic [2:0]          r_cnt, w_cnt;

  logic                w_redir;
  logic [PC_WIDTH-1:0] w_tgt;
  logic [PC_WIDTH-1:0] w_seq;

  assign w_redir = bus.br_taken | bus.jmp;
  assign w_tgt   = bus.br_taken ? bus.br_target
                                : bus.jmp_target;
  assign w_seq   = bus.pc + W_INC;

  always_comb begin
    w_state = r_state;
    w_npc   = r_npc;
    w_pc_en = r_pc_en;
    w_iv    = r_iv;
    w_busy  = r_busy;
    w_pend  = r_pend;
    w_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_state = RUN;
        w_npc   = W_RST;
        w_pc_en = 1'b1;
        w_iv    = 1'b0;
      end
      RUN, FLUSH: begin
        if (bus.stall) begin
          w_pc_en = 1'b0;
          w_iv    = 1'b0;
          w_state = STALL;
          if (w_redir) begin
            w_busy = 1'b1;
            w_pend = w_tgt;
          end
        end else if (w_redir) begin
          w_npc   = w_tgt;
          w_pc_en = 1'b1;
          w_iv    = 1'b0;
          w_cnt   = CNT_INIT;
          w_state = POST_REDIR;
        end else if (r_state == RUN) begin
          w_npc   = w_seq;
          w_pc_en = 1'b1;
          w_iv    = 1'b1;
        end else begin
          w_npc   = w_seq;
          w_pc_en = 1'b1;
          w_iv    = 1'b0;
          w_cnt   = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) w_state = RUN;
        end
      end
      STALL: begin
        if (bus.stall) begin
          w_pc_en = 1'b0;
          w_iv    = 1'b0;
          if (w_redir) begin
            w_busy = 1'b1;
            w_pend = w_tgt;
          end
        end else if (w_redir || r_busy) begin
          // a redirect on the release cycle is newer than the latched one
          w_npc   = w_redir ? w_tgt : r_pend;
          w_busy  = 1'b0;
          w_pc_en = 1'b1;
          w_iv    = 1'b0;
          w_cnt   = CNT_INIT;
          w_state = POST_REDIR;
        end else begin
          w_npc   = w_seq;
          w_pc_en = 1'b1;
          w_iv    = 1'b1;
          w_state = RUN;
        end
      end
      HALT: begin
        w_pc_en = 1'b0;
        w_iv    = 1'b0;
      end
      default: w_state = IDLE;
    endcase
    if (r_state != IDLE && bus.halt) begin
      w_npc   = r_npc;
      w_cnt   = r_cnt;
      w_pc_en = 1'b0;
      w_iv    = 1'b0;
      w_state = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_npc   <= W_RST;
      r_pc_en <= 1'b1;
      r_iv    <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_npc   <= w_npc;
      r_pc_en <= w_pc_en;
      r_iv    <= w_iv;
      r_busy  <= w_busy;
      r_pend  <= w_pend;
      r_cnt   <= w_cnt;
    end
  end

  assign bus.npc        = r_npc;
  assign bus.pc_en      = r_pc_en;
  assign bus.if_valid   = r_iv;
  assign bus.busy_redir = r_busy;

endmodule

// File: tb/tb_fetch_npc_gen.sv
// Directed bench for fetch_npc_gen with pc optionally fed back
// from npc.
module tb_fetch_npc_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        use_fb;
  logic [31:0] pc_drv;
  int          checks = 0;
  int          errors = 0;

  fetch_npc_if #(.PC_WIDTH(32)) bus();

  assign bus.pc = use_fb ? bus.npc : pc_drv;

  fetch_npc_gen #(
    .PC_WIDTH(32), .RESET_PC(0),
    .PC_INC(1), .FLUSH_CYCLES(1)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    use_fb         = 1'b1;
    pc_drv         = '0;
    bus.stall      = 1'b0;
    bus.halt       = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;
    bus.jmp        = 1'b0;
    bus.jmp_target = '0;

    step();
    chk("rst_npc", bus.npc, 32'd0);
    chk("rst_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rst_iv", 32'(bus.if_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy_redir), 32'd0);

    rst_n = 1'b1;
    step();
    chk("idle_npc", bus.npc, 32'd0);
    chk("idle_iv", 32'(bus.if_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_npc", bus.npc, 32'(i));
      chk("seq_iv", 32'(bus.if_valid), 32'd1);
    end

    use_fb        = 1'b0;
    pc_drv        = 32'd5;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd40;
    step();
    chk("br_npc", bus.npc, 32'd40);
    chk("br_iv", 32'(bus.if_valid), 32'd0);
    chk("br_pc_en", 32'(bus.pc_en), 32'd1);
    bus.br_taken = 1'b0;
    use_fb       = 1'b1;
    step();
    chk("br_next_npc", bus.npc, 32'd41);
    chk("br_next_iv", 32'(bus.if_valid), 32'd1);

    bus.stall = 1'b1;
    step();
    chk("st1_pc_en", 32'(bus.pc_en), 32'd0);
    chk("st1_npc", bus.npc, 32'd41);
    chk("st1_iv", 32'(bus.if_valid), 32'd0);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd100;
    step();
    chk("st2_busy", 32'(bus.busy_redir), 32'd1);
    chk("st2_pc_en", 32'(bus.pc_en), 32'd0);
    bus.br_taken = 1'b0;
    step();
    chk("st3_busy", 32'(bus.busy_redir), 32'd1);
    chk("st3_npc", bus.npc, 32'd41);
    bus.stall = 1'b0;
    step();
    chk("rel_npc", bus.npc, 32'd100);
    chk("rel_busy", 32'(bus.busy_redir), 32'd0);
    chk("rel_iv", 32'(bus.if_valid), 32'd0);
    chk("rel_pc_en", 32'(bus.pc_en), 32'd1);
    step();
    chk("rel2_npc", bus.npc, 32'd101);
    chk("rel2_iv", 32'(bus.if_valid), 32'd1);

    bus.br_taken   = 1'b1;
    bus.br_target  = 32'd8;
    bus.jmp        = 1'b1;
    bus.jmp_target = 32'd16;
    step();
    chk("prio_npc", bus.npc, 32'd8);
    bus.br_taken = 1'b0;
    step();
    chk("jmp_npc", bus.npc, 32'd16);
    bus.jmp = 1'b0;
    step();
    chk("jmp_next_npc", bus.npc, 32'd17);

    use_fb = 1'b0;
    pc_drv = 32'hFFFF_FFFF;
    step();
    chk("wrap_npc", bus.npc, 32'd0);
    chk("wrap_iv", 32'(bus.if_valid), 32'd1);
    use_fb = 1'b1;

    bus.stall      = 1'b1;
    bus.jmp        = 1'b1;
    bus.jmp_target = 32'd77;
    step();
    chk("pend_busy", 32'(bus.busy_redir), 32'd1);
    bus.jmp  = 1'b0;
    rst_n    = 1'b0;
    bus.halt = 1'b1;
    step();
    chk("rst2_npc", bus.npc, 32'd0);
    chk("rst2_busy", 32'(bus.busy_redir), 32'd0);
    chk("rst2_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rst2_iv", 32'(bus.if_valid), 32'd0);
    bus.halt  = 1'b0;
    bus.stall = 1'b0;
    rst_n     = 1'b1;
    step();
    step();
    chk("post_rst_npc", bus.npc, 32'd1);
    chk("post_rst_busy", 32'(bus.busy_redir), 32'd0);

    bus.halt = 1'b1;
    step();
    chk("halt_pc_en", 32'(bus.pc_en), 32'd0);
    chk("halt_iv", 32'(bus.if_valid), 32'd0);
    bus.halt      = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd50;
    step();
    chk("halt2_pc_en", 32'(bus.pc_en), 32'd0);
    chk("halt2_npc", bus.npc, 32'd1);
    bus.br_taken = 1'b0;
    step();
    chk("halt3_pc_en", 32'(bus.pc_en), 32'd0);
    chk("halt3_iv", 32'(bus.if_valid), 32'd0);
    rst_n = 1'b0;
    step();
    chk("unhalt_pc_en", 32'(bus.pc_en), 32'd1);
    chk("unhalt_npc", bus.npc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
